// File: rtl/vco_band_cal_pkg.sv
// Shared types and default timing for the VCO coarse band calibration controller.
package vco_band_cal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COUNT,
        ST_DRAIN,
        ST_COMPARE,
        ST_DONE
    } cal_state_t;

    typedef struct packed {
        int settle_cyc;
        int win_cyc;
        int drain_cyc;
    } cal_timing_t;

    localparam cal_timing_t CAL_TIMING_DEF = '{settle_cyc: 16, win_cyc: 256, drain_cyc: 4};

    // Phase timer width; must hold the longest phase (the count window).
    localparam int TIMER_W = 16;

endpackage

// File: rtl/vco_band_cal_if.sv
// Request/status bundle between the PLL top and the band calibration controller.
interface vco_band_cal_if #(
    parameter int TUNE_W = 5,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [CNT_W-1:0]  target_cnt;
    logic [TUNE_W-1:0] tune;
    logic              vctrl_hold;
    logic              busy;
    logic              done;
    logic              cal_err;
    logic [CNT_W-1:0]  last_cnt;

    modport master (
        output start, target_cnt,
        input  tune, vctrl_hold, busy, done, cal_err, last_cnt
    );

    modport slave (
        input  start, target_cnt,
        output tune, vctrl_hold, busy, done, cal_err, last_cnt
    );
endinterface

// File: rtl/vco_edge_counter.sv
// Saturating VCO rising-edge counter in the vco_clk domain with 2-FF synchronized enable/clear.
module vco_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             vco_clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);
    logic en_p0, en_p1;
    logic clr_p0, clr_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge vco_clk or negedge rst_n) begin
        if (!rst_n) begin
            en_p0  <= 1'b0;
            en_p1  <= 1'b0;
            clr_p0 <= 1'b0;
            clr_p1 <= 1'b0;
            count  <= '0;
        end else begin
            en_p0  <= en;
            en_p1  <= en_p0;
            clr_p0 <= clr;
            clr_p1 <= clr_p0;
            if (clr_p1)
                count <= '0;
            else if (en_p1)
                count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/vco_band_cal.sv
// Coarse VCO band-select calibration: SAR search over tune, one counted refclk window per bit.
module vco_band_cal
    import vco_band_cal_pkg::*;
#(
    parameter int TUNE_W     = 5,
    parameter int CNT_W      = 16,
    parameter int WIN_CYC    = CAL_TIMING_DEF.win_cyc,
    parameter int SETTLE_CYC = CAL_TIMING_DEF.settle_cyc,
    parameter int DRAIN_CYC  = CAL_TIMING_DEF.drain_cyc,
    parameter logic [TUNE_W-1:0] TUNE_RST = {1'b0, {(TUNE_W-1){1'b1}}}
) (
    input logic           refclk,
    input logic           rst_n,
    input logic           vco_clk,
    vco_band_cal_if.slave cal
);
    localparam int IDX_W = (TUNE_W > 1) ? $clog2(TUNE_W) : 1;

    cal_state_t         state_q, state_d;
    logic [TIMER_W-1:0] tmr_q, tmr_limit;
    logic               tmr_last;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   target_q, last_q, vco_count;
    logic [TUNE_W-1:0]  tune_q;
    logic               busy_q, hold_q, done_q, err_q;
    logic               cnt_en_q, cnt_clr_q;
    logic               cnt_zero, cnt_sat, step_high;

    assign tmr_last  = (tmr_q == tmr_limit - 1'b1);
    assign cnt_zero  = (last_q == '0);
    assign cnt_sat   = (last_q == '1);
    // A saturated window means the VCO is above any reachable target.
    assign step_high = cnt_sat || (last_q > target_q);

    always_comb begin
        tmr_limit = '0;
        case (state_q)
            ST_SETTLE: tmr_limit = TIMER_W'(SETTLE_CYC);
            ST_COUNT:  tmr_limit = TIMER_W'(WIN_CYC);
            ST_DRAIN:  tmr_limit = TIMER_W'(DRAIN_CYC);
            default:   tmr_limit = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (cal.start) state_d = ST_SETTLE;
            ST_SETTLE:  if (tmr_last) state_d = ST_COUNT;
            ST_COUNT:   if (tmr_last) state_d = ST_DRAIN;
            ST_DRAIN:   if (tmr_last) state_d = ST_COMPARE;
            ST_COMPARE: state_d = (idx_q == '0) ? ST_DONE : ST_SETTLE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tmr_q     <= '0;
            idx_q     <= '0;
            target_q  <= '0;
            last_q    <= '0;
            tune_q    <= TUNE_RST;
            busy_q    <= 1'b0;
            hold_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= (state_d != state_q) ? '0 : tmr_q + 1'b1;
            cnt_en_q  <= (state_d == ST_COUNT);
            // Clear the counter at every new search and before every further SAR step.
            cnt_clr_q <= ((state_q == ST_IDLE) && cal.start) ||
                         ((state_q == ST_COMPARE) && (idx_q != '0));
            case (state_q)
                ST_IDLE: begin
                    if (cal.start) begin
                        target_q <= cal.target_cnt;
                        idx_q    <= IDX_W'(TUNE_W - 1);
                        tune_q   <= TUNE_W'(1) << (TUNE_W - 1);
                        busy_q   <= 1'b1;
                        hold_q   <= 1'b1;
                        done_q   <= 1'b0;
                        err_q    <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (tmr_last) last_q <= vco_count;
                end
                ST_COMPARE: begin
                    if (cnt_zero || cnt_sat) err_q <= 1'b1;
                    if (step_high) tune_q[idx_q] <= 1'b0;
                    if (idx_q != '0) begin
                        tune_q[idx_q - 1'b1] <= 1'b1;
                        idx_q                <= idx_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    busy_q <= 1'b0;
                    hold_q <= 1'b0;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    vco_edge_counter #(.CNT_W(CNT_W)) u_edge_counter (
        .vco_clk (vco_clk),
        .rst_n   (rst_n),
        .en      (cnt_en_q),
        .clr     (cnt_clr_q),
        .count   (vco_count)
    );

    assign cal.tune       = tune_q;
    assign cal.vctrl_hold = hold_q;
    assign cal.busy       = busy_q;
    assign cal.done       = done_q;
    assign cal.cal_err    = err_q;
    assign cal.last_cnt   = last_q;

endmodule

// File: doc/vco_band_cal.md
Name: vco_band_cal

Overview:
Coarse band-select calibration controller for the 5-bit-tuned VCO. It holds the VCO control voltage at mid-rail, then runs a 5-step successive-approximation search over `tune`. Each step counts VCO edges over a fixed refclk window and compares the count against a target. It sits beside the VCO in the PLL top; `vctrl_hold` steers the loop-filter/VcoIn mux, and `tune` drives the VCO directly.

Parameters:
- TUNE_W, 5, tune code width (SAR steps = TUNE_W).
- CNT_W, 16, VCO edge-counter width.
- WIN_CYC, 256, refclk cycles per count window.
- SETTLE_CYC, 16, refclk cycles waited after each tune change before counting.
- DRAIN_CYC, 4, refclk cycles after window close before sampling the count (CDC settle).
- TUNE_RST, 5'b01111, tune value at reset and while idle before any calibration.

Ports:
- refclk  in  1  controller clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin calibration.
- target_cnt  in  CNT_W  expected VCO rising edges per window; sampled on accepted start.
- vco_clk  in  1  digital VCO output (sign of VcoOut, i.e. VcoOut > 0).
- tune  out  TUNE_W  VCO band code.
- vctrl_hold  out  1  1 = force VcoIn to mid-rail during calibration.
- busy  out  1  calibration in progress.
- done  out  1  calibration complete; level, cleared by the next accepted start.
- cal_err  out  1  a window returned count 0 or saturated; sticky until next start.
- last_cnt  out  CNT_W  count from the most recent window.

Behaviour:
- Reset values: tune=TUNE_RST, vctrl_hold=0, busy=0, done=0, cal_err=0, last_cnt=0, FSM=IDLE.
- Reset mid-calibration aborts immediately to the reset values; the edge counter is also cleared.
- Rule: monotonic VCO, i.e. higher tune gives higher frequency.
- IDLE: start=1 moves to SETTLE on the next edge.
  - On accept: latch target_cnt, bit index i=TUNE_W-1, tune=1<<(TUNE_W-1), busy=1, vctrl_hold=1, done=0, cal_err=0.
- Start is ignored while busy=1.
- SETTLE: wait SETTLE_CYC cycles, then assert count-enable and go to COUNT.
- COUNT: enable held exactly WIN_CYC refclk cycles, then deasserted; go to DRAIN.
- DRAIN: wait DRAIN_CYC cycles, sample the counter into last_cnt, go to COMPARE.
- COMPARE (1 cycle):
  - If last_cnt > target, clear tune[i]. Equal keeps the bit.
  - If i>0: set tune[i-1], decrement i, counter clear pulse, go to SETTLE.
  - If i==0: go to DONE.
- DONE (1 cycle): busy=0, vctrl_hold=0, done=1, return to IDLE. tune keeps the final code.
- Total latency from start to done = 1 + TUNE_W*(SETTLE_CYC+WIN_CYC+DRAIN_CYC+1) + 1 cycles (default 1387).
- Counter saturation:
  - Saturates at all-ones and never wraps.
  - A saturated count sets cal_err and compares as > target.
  - A count of 0 sets cal_err; the bit is kept (treated as below target).
- CDC:
  - Count-enable and clear are 2-FF synchronized into the vco_clk domain.
  - The count is stable for DRAIN_CYC ≥ 4, given f_vco > refclk.
  - The count is read as a quasi-static bus; no Gray coding is required at DRAIN_CYC ≥ 4.

Decomposition:
- Shared package: FSM state enum (IDLE, SETTLE, COUNT, DRAIN, COMPARE, DONE) and the cal_timing_t struct constants.
- Sub-module vco_edge_counter (vco_clk domain): synchronizers, saturating CNT_W counter with clear/enable.
- The controller FSM and SAR logic stay in vco_band_cal (refclk domain).

Test Plan:
- Ideal model: refclk 100 MHz, f_vco = 1.0 GHz + tune*50 MHz (count = 2560 + 128*tune), target_cnt=4992 -> done after 1387 cycles, tune=5'b10011, cal_err=0.
- Exact-match boundary: target_cnt = 2560 + 128*16 -> first step keeps bit4; final tune=5'b10000.
- Out of range: target_cnt=0xFFFF -> tune=5'b11111. target_cnt=0 -> tune=5'b00000. cal_err=0 in both.
- Dead VCO (vco_clk stuck 0) -> every last_cnt=0, cal_err=1, tune=5'b11111, done=1.
- Reset mid-COUNT of step 3 -> tune=5'b01111, busy=0, done=0 at once. A new start runs a full calibration to the correct code.
- Start pulsed while busy at step 2 -> ignored; latency and result identical to the uninterrupted run. A start in the cycle after done re-calibrates and clears done.
